// File: rtl/shift_reg_4_pkg.sv
// Shared constants for the bidirectional serial-in, parallel-out shift register.
// Latency: none (constants only).
// Backpressure: none (constants only).
package shift_reg_4_pkg;

    // Encoding of the direction-select input: 1 moves bits toward the MSB.
    localparam logic DIR_LEFT = 1'b1;

endpackage

// File: rtl/shift_reg_4.sv
// Bidirectional serial-in, parallel-out shift register; `in` fills the vacated end.
// Latency: `in`/`left` sampled at a rising edge appear on `q` right after that edge.
// Backpressure: none; every non-reset rising edge shifts, no hold or enable.
module shift_reg_4
    import shift_reg_4_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             left,
    input  logic             in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_next;

    // Direction mux: the bit falling off one end is dropped, `in` enters the other.
    always_comb begin
        q_next = q;
        if (left == DIR_LEFT) begin
            q_next = {q[WIDTH-2:0], in};
        end else begin
            q_next = {in, q[WIDTH-1:1]};
        end
    end

    // State register: asynchronous clear, otherwise shift on every rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: tb/tb_shift_reg_4.sv
// Self-checking bench for shift_reg_4 using a scoreboard queue and an arithmetic model.
// Latency: expected value for each edge is checked 1 time unit after that edge.
// Backpressure: not applicable.
module tb_shift_reg_4;

    localparam int W   = 4;
    localparam int MOD = 2 ** W;

    logic         clk;
    logic         rst;
    logic         left;
    logic         in;
    logic [W-1:0] q;

    shift_reg_4 #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .left (left),
        .in   (in),
        .q    (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: expected values and their check names, in issue order.
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    event         async_ev;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state, as an integer register value.
    int model = 0;

    // Monitor: after every rising edge (or an asynchronous-reset probe) compare q.
    always begin
        logic [W-1:0] e;
        string        n;
        @(posedge clk or async_ev);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            tests_run++;
            if (q !== e) begin
                tests_failed++;
                $display("FAIL %s: q=%b expected %b at %0t", n, q, e, $time);
            end
        end
    end

    function automatic int model_shift(input int m, input bit l, input bit d);
        if (l) return (m * 2 + int'(d)) % MOD;
        else   return m / 2 + int'(d) * (MOD / 2);
    endfunction

    // One clock of stimulus: drive on the falling edge, predict the next rising edge.
    task automatic step(input bit l, input bit d, input bit r, input string nm);
        @(negedge clk);
        rst  = r;
        left = l;
        in   = d;
        model = r ? 0 : model_shift(model, l, d);
        exp_q.push_back(W'(model));
        name_q.push_back(nm);
    endtask

    // Assert reset mid-cycle with clk low and check q clears without an edge.
    task automatic async_reset(input string nm);
        @(negedge clk);
        #1;
        rst   = 1'b1;
        model = 0;
        exp_q.push_back('0);
        name_q.push_back(nm);
        ->async_ev;
        #2;
    endtask

    bit l_pat[$];
    bit d_pat[$];

    initial begin
        rst  = 1'b1;
        left = 1'b0;
        in   = 1'b0;
        #2;
        exp_q.push_back('0);
        name_q.push_back("reset_state");
        ->async_ev;
        #2;

        // Hold reset across two edges.
        step(1, 1, 1, "reset_hold0");
        step(0, 1, 1, "reset_hold1");

        // Left fill from zero.
        d_pat = '{0, 0, 1, 0, 1, 1, 1, 1};
        foreach (d_pat[i]) step(1, d_pat[i], 0, "left_fill");

        // Right shift from 1111.
        foreach (d_pat[i]) step(0, d_pat[i], 0, "right_shift");

        // Async reset with q nonzero, then direction toggling from zero.
        async_reset("async_reset_nonzero");
        l_pat = '{1, 0, 1, 1};
        d_pat = '{1, 1, 0, 1};
        foreach (l_pat[i]) step(l_pat[i], d_pat[i], 0, "dir_toggle");

        // Walk a single 1 to the MSB and off the end, then mirror.
        async_reset("async_reset_walk");
        step(1, 1, 0, "walk_left");
        repeat (4) step(1, 0, 0, "walk_left");
        async_reset("async_reset_walk_r");
        step(0, 1, 0, "walk_right");
        repeat (4) step(0, 0, 0, "walk_right");

        // Mid-stream reset at 1011, then release and shift.
        async_reset("async_reset_pre");
        d_pat = '{1, 0, 1, 1};
        foreach (d_pat[i]) step(1, d_pat[i], 0, "mid_fill");
        async_reset("mid_stream_reset");
        step(1, 1, 0, "after_release");

        // Randomized phase with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                async_reset("rand_async_reset");
                repeat ($urandom_range(0, 2)) step(1'($urandom), 1'($urandom), 1, "rand_reset_hold");
            end
            step(1'($urandom), 1'($urandom), 0, "rand_shift");
        end

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
